// File: rtl/q_table_update.sv
`default_nettype none
// ============================================================================
// Module   : q_table_update
// Purpose  : Q-learning table writer. Owns the 6x4 Q-table and applies
//            Q += (R + gamma_maxQ - Q) >>> ALPHA_SHIFT in a two-stage
//            pipeline with same-address forwarding, saturation, and
//            per-state running max outputs.
// Revision : 1.0 - initial release
// ============================================================================
module q_table_update #(
    parameter int                 DEPTH       = 24,
    parameter int                 ALPHA_SHIFT = 3,
    parameter logic signed [23:0] INIT_Q      = 24'sd0
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       init,
    input  logic                       upd_valid,
    output logic                       upd_ready,
    input  logic [$clog2(DEPTH)-1:0]   addr,
    input  logic [23:0]                Reward,
    input  logic [23:0]                gamma_maxQ,
    output logic                       upd_done,
    output logic                       addr_err,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [23:0]                rd_data,
    output logic [23:0]                Max_Q0,
    output logic [23:0]                Max_Q1,
    output logic [23:0]                Max_Q2,
    output logic [23:0]                Max_Q3,
    output logic [23:0]                Max_Q4,
    output logic [23:0]                Max_Q5
);

    localparam int                   c_aw     = $clog2(DEPTH);
    localparam int                   c_nstate = 6;
    localparam logic [c_aw:0]        c_depth  = (c_aw+1)'(DEPTH);
    localparam logic signed [25:0]   c_qmax   = 26'sd8388607;
    localparam logic signed [25:0]   c_qmin   = -26'sd8388608;

    logic signed [23:0] r_q    [0:DEPTH-1];
    logic signed [23:0] r_maxq [0:c_nstate-1];

    logic               r_ready;
    logic               r_s2_valid;
    logic [c_aw-1:0]    r_s2_addr;
    logic signed [23:0] r_s2_q;
    logic               r_done;
    logic               r_addr_err;

    logic               w_acc;
    logic               w_in_range;
    logic               w_fwd;
    logic signed [23:0] w_qold;
    logic signed [25:0] w_td;
    logic signed [25:0] w_step;
    logic signed [25:0] w_sum;
    logic signed [23:0] w_qnew;
    logic [c_aw-3:0]    w_wr_state;
    logic signed [23:0] w_row [0:3];
    logic signed [23:0] w_max01;
    logic signed [23:0] w_max23;
    logic signed [23:0] w_max;

    // init wins over a same-cycle request, which is simply not accepted
    assign w_acc      = upd_valid && r_ready && !init;
    assign w_in_range = ({1'b0, addr} < c_depth);

    // The previous request is still in the stage-2 register and is written
    // on this same edge, so its result must be used instead of the table.
    assign w_fwd  = r_s2_valid && (r_s2_addr == addr);
    assign w_qold = w_fwd ? r_s2_q : (w_in_range ? r_q[addr] : INIT_Q);

    assign w_td   = $signed({{2{Reward[23]}}, Reward})
                  + $signed({{2{gamma_maxQ[23]}}, gamma_maxQ})
                  - $signed({{2{w_qold[23]}}, w_qold});
    assign w_step = w_td >>> ALPHA_SHIFT;
    assign w_sum  = $signed({{2{w_qold[23]}}, w_qold}) + w_step;

    always_comb begin
        w_qnew = w_sum[23:0];
        if (w_sum > c_qmax) begin
            w_qnew = c_qmax[23:0];
        end else if (w_sum < c_qmin) begin
            w_qnew = c_qmin[23:0];
        end
    end

    // Row of the state being written, with the new value substituted
    assign w_wr_state = r_s2_addr[c_aw-1:2];

    generate
        for (genvar g = 0; g < 4; g++) begin : g_row
            localparam logic [1:0] c_act = 2'(g);
            assign w_row[g] = (r_s2_addr[1:0] == c_act) ? r_s2_q
                                                        : r_q[{w_wr_state, c_act}];
        end
    endgenerate

    assign w_max01 = (w_row[0] > w_row[1]) ? w_row[0] : w_row[1];
    assign w_max23 = (w_row[2] > w_row[3]) ? w_row[2] : w_row[3];
    assign w_max   = (w_max01 > w_max23) ? w_max01 : w_max23;

    always_ff @(posedge CLK) begin
        if (!RST || init) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_q[i] <= INIT_Q;
            end
            for (int i = 0; i < c_nstate; i++) begin
                r_maxq[i] <= INIT_Q;
            end
            r_ready    <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_addr  <= '0;
            r_s2_q     <= INIT_Q;
            r_done     <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_ready    <= 1'b1;
            r_s2_valid <= w_acc && w_in_range;
            r_addr_err <= w_acc && !w_in_range;
            r_done     <= r_s2_valid;
            if (w_acc && w_in_range) begin
                r_s2_addr <= addr;
                r_s2_q    <= w_qnew;
            end
            if (r_s2_valid) begin
                r_q[r_s2_addr]     <= r_s2_q;
                r_maxq[w_wr_state] <= w_max;
            end
        end
    end

    assign upd_ready = r_ready;
    assign upd_done  = r_done;
    assign addr_err  = r_addr_err;
    assign rd_data   = ({1'b0, rd_addr} < c_depth) ? r_q[rd_addr] : 24'd0;

    assign Max_Q0 = r_maxq[0];
    assign Max_Q1 = r_maxq[1];
    assign Max_Q2 = r_maxq[2];
    assign Max_Q3 = r_maxq[3];
    assign Max_Q4 = r_maxq[4];
    assign Max_Q5 = r_maxq[5];

endmodule
`default_nettype wire

// File: tb/tb_q_table_update.sv
`default_nettype none
// ============================================================================
// Module   : tb_q_table_update
// Purpose  : Directed self-checking bench for q_table_update with a
//            reference model and an in-order scoreboard of write/error events.
// Revision : 1.0 - initial release
// ============================================================================
module tb_q_table_update;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init;
    logic        upd_valid;
    logic        upd_ready;
    logic [4:0]  addr;
    logic [23:0] reward;
    logic [23:0] gamma_maxq;
    logic        upd_done;
    logic        addr_err;
    logic [4:0]  rd_addr;
    logic [23:0] rd_data;
    logic [23:0] dmax [6];

    int ncmp  = 0;
    int nfail = 0;
    int cyc   = 0;

    typedef struct {
        logic        err;
        logic [4:0]  a;
        logic [23:0] q;
        logic [23:0] mx;
        int          due;
    } sb_t;

    sb_t         sb [$];
    logic [23:0] mq [24];
    logic [23:0] mmax [6];

    always #5 clk = ~clk;

    q_table_update #(
        .DEPTH       (24),
        .ALPHA_SHIFT (3),
        .INIT_Q      (24'sd0)
    ) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .init       (init),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .addr       (addr),
        .Reward     (reward),
        .gamma_maxQ (gamma_maxq),
        .upd_done   (upd_done),
        .addr_err   (addr_err),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .Max_Q0     (dmax[0]),
        .Max_Q1     (dmax[1]),
        .Max_Q2     (dmax[2]),
        .Max_Q3     (dmax[3]),
        .Max_Q4     (dmax[4]),
        .Max_Q5     (dmax[5])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] qupd(input logic [23:0] q, input logic [23:0] r,
                                         input logic [23:0] g);
        longint lq, td, s;
        lq = longint'($signed(q));
        td = longint'($signed(r)) + longint'($signed(g)) - lq;
        s  = lq + (td >>> 3);
        if (s > 64'sd8388607)       s = 64'sd8388607;
        else if (s < -64'sd8388608) s = -64'sd8388608;
        return s[23:0];
    endfunction

    function automatic logic [23:0] smax(input int s);
        logic [23:0] m;
        m = mq[s*4];
        for (int k = 1; k < 4; k++) begin
            if ($signed(mq[s*4+k]) > $signed(m)) m = mq[s*4+k];
        end
        return m;
    endfunction

    task automatic clear_model();
        sb.delete();
        for (int i = 0; i < 24; i++) mq[i] = 24'd0;
        for (int i = 0; i < 6; i++)  mmax[i] = 24'd0;
    endtask

    // One clock: retire scoreboard events, then check every Max_Q register
    task automatic tick();
        sb_t it;
        @(posedge clk);
        #1;
        cyc++;
        if (upd_done === 1'b1) begin
            if (sb.size() == 0 || sb[0].err) begin
                chk("done_unexpected", 32'd1, 32'd0);
            end else begin
                it = sb.pop_front();
                chk("done_latency", cyc, it.due);
                rd_addr = it.a;
                #1;
                chk("q_write", rd_data, it.q);
                mmax[it.a[4:2]] = it.mx;
            end
        end
        if (addr_err === 1'b1) begin
            if (sb.size() == 0 || !sb[0].err) begin
                chk("err_unexpected", 32'd1, 32'd0);
            end else begin
                it = sb.pop_front();
                chk("err_latency", cyc, it.due);
            end
        end
        while (sb.size() > 0 && sb[0].due < cyc) begin
            it = sb.pop_front();
            chk(it.err ? "err_missing" : "done_missing", 32'd0, 32'd1);
        end
        for (int s = 0; s < 6; s++) begin
            chk($sformatf("max_q%0d", s), dmax[s], mmax[s]);
        end
    endtask

    task automatic step(input logic v, input logic [4:0] a, input logic [23:0] r,
                        input logic [23:0] g, input logic in_init);
        sb_t it;
        upd_valid  = v;
        addr       = a;
        reward     = r;
        gamma_maxq = g;
        init       = in_init;
        if (in_init) begin
            clear_model();
        end else if (v && upd_ready === 1'b1) begin
            it.a  = a;
            it.q  = 24'd0;
            it.mx = 24'd0;
            if (a >= 5'd24) begin
                it.err = 1'b1;
                it.due = cyc + 1;
            end else begin
                mq[a]  = qupd(mq[a], r, g);
                it.err = 1'b0;
                it.q   = mq[a];
                it.mx  = smax(int'(a[4:2]));
                it.due = cyc + 2;
            end
            sb.push_back(it);
        end
        tick();
        upd_valid = 1'b0;
        init      = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 5'd0, 24'd0, 24'd0, 1'b0);
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 24; i++) begin
            rd_addr = 5'(i);
            #1;
            chk(tag, rd_data, mq[i]);
        end
    endtask

    task automatic read_chk(input string tag, input logic [4:0] a, input logic [23:0] exp);
        rd_addr = a;
        #1;
        chk(tag, rd_data, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        init       = 1'b0;
        upd_valid  = 1'b0;
        addr       = 5'd0;
        reward     = 24'd0;
        gamma_maxq = 24'd0;
        rd_addr    = 5'd0;
        clear_model();

        // Reset and release
        tick();
        tick();
        rst_n = 1'b1;
        chk("ready_at_release", upd_ready, 32'd0);
        tick();
        chk("ready_after_release", upd_ready, 32'd1);
        check_table("rst_table");

        // Single update
        step(1'b1, 5'd5, 24'h010000, 24'h000000, 1'b0);
        idle(2);
        read_chk("single_q5", 5'd5, 24'h002000);
        chk("single_maxq1", dmax[1], 32'h002000);

        // init with a same-cycle request: request ignored, one not-ready cycle
        step(1'b1, 5'd5, 24'h010000, 24'h000000, 1'b1);
        chk("ready_after_init", upd_ready, 32'd0);
        read_chk("init_q5", 5'd5, 24'h000000);
        idle(1);
        chk("ready_init_recover", upd_ready, 32'd1);

        // Back-to-back same address exercises forwarding
        step(1'b1, 5'd5, 24'h010000, 24'h000000, 1'b0);
        step(1'b1, 5'd5, 24'h010000, 24'h000000, 1'b0);
        idle(3);
        read_chk("fwd_q5", 5'd5, 24'h003C00);

        // Saturation high on Q[0] and low on Q[1], both back-to-back
        for (int i = 0; i < 10; i++) step(1'b1, 5'd0, 24'h7FFFFF, 24'h7FFFFF, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b1, 5'd1, 24'h800000, 24'h800000, 1'b0);
        idle(3);
        read_chk("sat_hi_q0", 5'd0, 24'h7FFFFF);
        read_chk("sat_lo_q1", 5'd1, 24'h800000);
        chk("sat_maxq0", dmax[0], 32'h7FFFFF);

        // Negative reward leaves the state max at the untouched zero entries
        step(1'b1, 5'd9, 24'hFF0000, 24'h000000, 1'b0);
        idle(3);
        read_chk("neg_q9", 5'd9, 24'hFFE000);
        chk("neg_maxq2", dmax[2], 32'h000000);

        // Interleaved addresses across states with mixed signs
        step(1'b1, 5'd22, 24'h123456, 24'h00F000, 1'b0);
        step(1'b1, 5'd13, 24'hFEDCBA, 24'h001000, 1'b0);
        step(1'b1, 5'd22, 24'h000100, 24'hFFF000, 1'b0);
        step(1'b1, 5'd23, 24'h200000, 24'h000000, 1'b0);
        idle(3);

        // Out-of-range address: error pulse, table untouched
        step(1'b1, 5'd26, 24'h010000, 24'h000000, 1'b0);
        idle(3);
        check_table("err_table");

        // init while a write is in flight: dropped, no upd_done
        step(1'b1, 5'd14, 24'h010000, 24'h000000, 1'b0);
        step(1'b1, 5'd14, 24'h010000, 24'h000000, 1'b1);
        chk("ready_after_init2", upd_ready, 32'd0);
        idle(4);
        check_table("init_table");

        chk("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
`default_nettype wire
